pipeline_writeback: RTL and testbench

- Final stage of the MIPS pipeline, directly downstream of the memory stage.
- Registers the memory-stage results and formats load data: byte/halfword lane select and sign/zero extension.
- Drives the register-file write port and the WB forwarding bus.
- Commits exceptions through a small flush/hold state machine that squashes younger instructions until software acknowledges.

---
 rtl/mips_pkg.sv | 18 +
 rtl/pipeline_writeback_load_align.sv | 45 ++++
 rtl/pipeline_writeback.sv | 153 +++++++++++++++
 tb/tb_pipeline_writeback.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: load sizes, exception codes, writeback FSM states.
// Pure declarations, no logic.
package mips_pkg;

    localparam logic [1:0] LS_BYTE = 2'd0;
    localparam logic [1:0] LS_HALF = 2'd1;
    localparam logic [1:0] LS_WORD = 2'd2;

    localparam logic [2:0] EXC_NONE = 3'd0;
    localparam logic [2:0] EXC_ADEL = 3'd4;

    typedef enum logic [1:0] {
        WB_RUN   = 2'd0,
        WB_FLUSH = 2'd1,
        WB_HOLD  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/pipeline_writeback_load_align.sv
// Load lane select, sign/zero extension and misalignment check (little-endian).
// Purely combinational, zero latency, no backpressure.
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [31:0] rdata_i,
    input  logic        is_load_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] data_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v       = rdata_i[7:0];
        half_v       = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o       = addr_i;
        misaligned_o = 1'b0;
        case (addr_i[1:0])
            2'd0:    byte_v = rdata_i[7:0];
            2'd1:    byte_v = rdata_i[15:8];
            2'd2:    byte_v = rdata_i[23:16];
            default: byte_v = rdata_i[31:24];
        endcase
        if (is_load_i) begin
            case (size_i)
                LS_BYTE: data_o = {{24{signed_i & byte_v[7]}}, byte_v};
                LS_HALF: begin
                    data_o       = {{16{signed_i & half_v[15]}}, half_v};
                    misaligned_o = addr_i[0];
                end
                // size 3 is treated as a word access
                default: begin
                    data_o       = rdata_i;
                    misaligned_o = (addr_i[1:0] != 2'b00);
                end
            endcase
        end
    end

endmodule

// File: rtl/pipeline_writeback.sv
// MIPS writeback stage: load formatting, RF write/forward, exception flush/hold FSM; 1-cycle registered latency, no backpressure.
// Optional WB_RETIRE_COUNTER_EN adds a wrapping 32-bit retire_count of committed non-faulting instructions.
module pipeline_writeback
    import mips_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter logic [2:0]  ADEL_CODE    = EXC_ADEL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] rd_value,
    input  logic [31:0] mem_out_value,
    input  logic        memread_enable,
    input  logic [1:0]  load_size,
    input  logic        load_signed,
    input  logic        regwrite_enable,
    input  logic [4:0]  rd_index,
    input  logic [2:0]  mem_exception,
    input  logic        exc_ack,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        fwd_valid,
    output logic        exc_valid,
    output logic [2:0]  exc_code,
    output logic [31:0] exc_pc,
    output logic        flush_out
`ifdef WB_RETIRE_COUNTER_EN
    ,
    output logic [31:0] retire_count
`endif
);

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    wb_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic        exc_valid_q, exc_valid_d;
    logic [2:0]  exc_code_q, exc_code_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q;

    logic [31:0] load_data;
    logic        misaligned;
    logic        fault;
    logic        run;

    load_align u_load_align (
        .addr_i       (rd_value),
        .rdata_i      (mem_out_value),
        .is_load_i    (memread_enable),
        .size_i       (load_size),
        .signed_i     (load_signed),
        .data_o       (load_data),
        .misaligned_o (misaligned)
    );

    assign fault   = valid_in & ((mem_exception != EXC_NONE) | misaligned);
    assign run     = (state_q == WB_RUN);
    assign rf_we_d = valid_in & regwrite_enable & (rd_index != 5'd0) & ~fault & run;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flush_d     = flush_q;
        exc_valid_d = exc_valid_q;
        exc_code_d  = exc_code_q;
        exc_pc_d    = exc_pc_q;
        case (state_q)
            WB_RUN: begin
                if (fault) begin
                    exc_code_d  = (mem_exception != EXC_NONE) ? mem_exception : ADEL_CODE;
                    exc_pc_d    = pc_in;
                    exc_valid_d = 1'b1;
                    flush_d     = 1'b1;
                    cnt_d       = CNT_INIT;
                    state_d     = WB_FLUSH;
                end
            end
            WB_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    flush_d = 1'b0;
                    state_d = WB_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WB_HOLD: begin
                if (exc_ack) begin
                    exc_valid_d = 1'b0;
                    state_d     = WB_RUN;
                end
            end
            default: state_d = WB_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= WB_RUN;
            cnt_q       <= 4'd0;
            flush_q     <= 1'b0;
            exc_valid_q <= 1'b0;
            exc_code_q  <= EXC_NONE;
            exc_pc_q    <= 32'd0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= 5'd0;
            rf_wdata_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            exc_valid_q <= exc_valid_d;
            exc_code_q  <= exc_code_d;
            exc_pc_q    <= exc_pc_d;
            rf_we_q     <= rf_we_d;
            // address/data hold their last written values between writes
            if (rf_we_d) begin
                rf_waddr_q <= rd_index;
                rf_wdata_q <= load_data;
            end
        end
    end

`ifdef WB_RETIRE_COUNTER_EN
    logic [31:0] retire_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_q <= 32'd0;
        end else if (valid_in & run & ~fault) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retire_count = retire_q;
`endif

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign fwd_valid = rf_we_q;
    assign exc_valid = exc_valid_q;
    assign exc_code  = exc_code_q;
    assign exc_pc    = exc_pc_q;
    assign flush_out = flush_q;

endmodule

// File: tb/tb_pipeline_writeback.sv
// Randomized and directed bench for pipeline_writeback against a behavioural model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_pipeline_writeback;

    localparam int FLUSH_N = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] rd_value = '0;
    logic [31:0] mem_out_value = '0;
    logic        memread_enable = 1'b0;
    logic [1:0]  load_size = '0;
    logic        load_signed = 1'b0;
    logic        regwrite_enable = 1'b0;
    logic [4:0]  rd_index = '0;
    logic [2:0]  mem_exception = '0;
    logic        exc_ack = 1'b0;

    logic        rf_we, fwd_valid, exc_valid, flush_out;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, exc_pc;
    logic [2:0]  exc_code;
`ifdef WB_RETIRE_COUNTER_EN
    logic [31:0] retire_count;
`endif

    pipeline_writeback #(.FLUSH_CYCLES(FLUSH_N), .ADEL_CODE(3'd4)) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_in        (valid_in),
        .pc_in           (pc_in),
        .rd_value        (rd_value),
        .mem_out_value   (mem_out_value),
        .memread_enable  (memread_enable),
        .load_size       (load_size),
        .load_signed     (load_signed),
        .regwrite_enable (regwrite_enable),
        .rd_index        (rd_index),
        .mem_exception   (mem_exception),
        .exc_ack         (exc_ack),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .fwd_valid       (fwd_valid),
        .exc_valid       (exc_valid),
        .exc_code        (exc_code),
        .exc_pc          (exc_pc),
        .flush_out       (flush_out)
`ifdef WB_RETIRE_COUNTER_EN
        ,
        .retire_count    (retire_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // model: an exception is pending from commit until acknowledged;
    // flush_left counts the flush_out cycles still to come
    logic        m_we, m_exc;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata, m_pc;
    logic [2:0]  m_code;
    int          flush_left;
    logic [31:0] m_retire;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] fmt_load(input logic [31:0] addr, input logic [31:0] mem,
                                             input logic [1:0] sz, input logic sgn);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (mem >> (8 * addr[1:0])) & 32'hFF;
            if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (mem >> (16 * addr[1])) & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = mem;
        end
        return v;
    endfunction

    function automatic logic misaligned(input logic [31:0] addr, input logic [1:0] sz);
        if (sz == 2'd1) return (addr % 2) != 0;
        if (sz >= 2'd2) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_we = 0; m_exc = 0; m_waddr = 0; m_wdata = 0; m_pc = 0; m_code = 0;
        flush_left = 0; m_retire = 0;
    endtask

    task automatic model_step();
        logic bad;
        bad = valid_in && (mem_exception != 0 || (memread_enable && misaligned(rd_value, load_size)));
        m_we = 0;
        if (m_exc) begin
            if (flush_left == 0 && exc_ack) m_exc = 0;
            else if (flush_left > 0) flush_left--;
        end else if (bad) begin
            m_exc = 1;
            m_pc = pc_in;
            m_code = (mem_exception != 0) ? mem_exception : 3'd4;
            flush_left = FLUSH_N;
        end else if (valid_in) begin
            m_retire = m_retire + 1;
            if (regwrite_enable && rd_index != 0) begin
                m_we = 1;
                m_waddr = rd_index;
                m_wdata = memread_enable ? fmt_load(rd_value, mem_out_value, load_size, load_signed)
                                         : rd_value;
            end
        end
    endtask

    task automatic check_all();
        check_val("rf_we", 32'(rf_we), 32'(m_we));
        check_val("fwd_valid", 32'(fwd_valid), 32'(m_we));
        check_val("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
        check_val("rf_wdata", rf_wdata, m_wdata);
        check_val("exc_valid", 32'(exc_valid), 32'(m_exc));
        check_val("exc_code", 32'(exc_code), 32'(m_code));
        check_val("exc_pc", exc_pc, m_pc);
        check_val("flush_out", 32'(flush_out), 32'(flush_left > 0));
`ifdef WB_RETIRE_COUNTER_EN
        check_val("retire_count", retire_count, m_retire);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] rdv,
                         input logic [31:0] mem, input logic ld, input logic [1:0] sz,
                         input logic sgn, input logic we, input logic [4:0] idx,
                         input logic [2:0] mexc, input logic ack);
        valid_in = v; pc_in = pc; rd_value = rdv; mem_out_value = mem;
        memread_enable = ld; load_size = sz; load_signed = sgn;
        regwrite_enable = we; rd_index = idx; mem_exception = mexc; exc_ack = ack;
    endtask

    task automatic alu_op(input logic [31:0] val, input logic [4:0] idx, input logic ack);
        drive(1, 32'h100, val, 32'h0, 0, 2'd2, 0, 1, idx, 3'd0, ack);
    endtask

    initial begin
        int flush_cnt;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // LB signed, lane 3
        drive(1, 32'h10, 32'h1003, 32'h80FF_1234, 1, 2'd0, 1, 1, 5'd5, 3'd0, 0);
        tick();
        check_val("lb_data", rf_wdata, 32'hFFFF_FF80);
        check_val("lb_we", 32'(rf_we), 32'd1);
        // LHU upper half
        drive(1, 32'h14, 32'h2002, 32'h8001_7FFF, 1, 2'd1, 0, 1, 5'd6, 3'd0, 0);
        tick();
        check_val("lhu_data", rf_wdata, 32'h0000_8001);
        // LW to r0
        drive(1, 32'h18, 32'h3000, 32'hDEAD_BEEF, 1, 2'd2, 0, 1, 5'd0, 3'd0, 0);
        tick();
        check_val("lw_r0_we", 32'(rf_we), 32'd0);

        // misaligned LW, then count flush cycles while valid ops are squashed
        drive(1, 32'h400, 32'h6, 32'h1111_1111, 1, 2'd2, 0, 1, 5'd7, 3'd0, 0);
        tick();
        check_val("adel_code", 32'(exc_code), 32'd4);
        check_val("adel_pc", exc_pc, 32'h400);
        flush_cnt = int'(flush_out);
        for (int i = 0; i < 5; i++) begin
            alu_op(32'hA0 + i, 5'd9, 0);
            tick();
            flush_cnt += int'(flush_out);
        end
        check_val("flush_len", 32'(flush_cnt), 32'(FLUSH_N));
        alu_op(32'h55, 5'd9, 1);
        tick();
        check_val("ack_clear", 32'(exc_valid), 32'd0);

        // memory exception wins over ADEL; second fault and ack in FLUSH ignored
        drive(1, 32'h500, 32'h3, 32'h0, 1, 2'd1, 0, 1, 5'd4, 3'd2, 0);
        tick();
        check_val("mexc_code", 32'(exc_code), 32'd2);
        drive(1, 32'h504, 32'h0, 32'h0, 0, 2'd2, 0, 1, 5'd4, 3'd5, 1);
        tick();
        check_val("second_fault", 32'(exc_code), 32'd2);
        check_val("ack_in_flush", 32'(exc_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            alu_op(32'hB0 + i, 5'd3, 0);
            tick();
        end
        alu_op(32'h77, 5'd3, 1);
        tick();

        // async reset in the middle of FLUSH
        drive(1, 32'h600, 32'h0, 32'h0, 0, 2'd2, 0, 1, 5'd2, 3'd1, 0);
        tick();
        alu_op(32'h1, 5'd2, 0);
        tick();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        check_val("rst_flush", 32'(flush_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        alu_op(32'hCAFE_F00D, 5'd12, 0);
        tick();
        check_val("post_rst_wdata", rf_wdata, 32'hCAFE_F00D);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(3) != 0, $urandom, $urandom, $urandom,
                  $urandom_range(1), 2'($urandom_range(3)), $urandom_range(1),
                  $urandom_range(3) != 0, 5'($urandom_range(31)),
                  ($urandom_range(15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                  $urandom_range(3) == 0);
            // keep some loads aligned so writes dominate
            if ($urandom_range(1) == 1) rd_value[1:0] = 2'b00;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
